// File: rtl/down_counter_reload_pkg.sv
// Shared types for the reloadable down counter: FSM states and mode encodings.
package down_counter_reload_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/down_counter_reload_if.sv
// Control/status bundle of the reloadable down counter.
interface down_counter_reload_if #(
  parameter int WIDTH = 3
);
  logic             start;
  logic             stop;
  logic             en;
  logic             mode;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             tc;

  modport master (
    output start, stop, en, mode, load_val,
    input  count, busy, done, tc
  );

  modport slave (
    input  start, stop, en, mode, load_val,
    output count, busy, done, tc
  );
endinterface

// File: rtl/down_counter_core.sv
// WIDTH-bit count register: clear > load > decrement, plus zero detect.
module down_counter_core #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             zero
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    count <= '0;
    else if (clr)  count <= '0;
    else if (load) count <= load_val;
    else if (dec)  count <= count - ONE;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/down_counter_reload.sv
// Programmable interval timer: one-shot or auto-reload down counter with a
// registered terminal-count pulse. stop beats start beats counting.
module down_counter_reload
  import down_counter_reload_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  down_counter_reload_if.slave bus
);
  state_e           state, nxt_state;
  logic [WIDTH-1:0] reload_reg;
  logic             mode_reg;
  logic             tc_r, tc_nxt;
  logic             clr, ld, ld_reload, dec, capture;
  logic [WIDTH-1:0] ld_val;
  logic             zero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      reload_reg <= '0;
      mode_reg   <= MODE_ONESHOT;
      tc_r       <= 1'b0;
    end else begin
      state <= nxt_state;
      tc_r  <= tc_nxt;
      if (capture) begin
        reload_reg <= bus.load_val;
        mode_reg   <= bus.mode;
      end
    end
  end

  always_comb begin
    nxt_state = state;
    clr       = 1'b0;
    ld        = 1'b0;
    ld_reload = 1'b0;
    dec       = 1'b0;
    tc_nxt    = 1'b0;
    capture   = 1'b0;
    if (bus.stop) begin
      clr       = 1'b1;
      nxt_state = IDLE;
    end else if (bus.start) begin
      // restart from any state; tc is suppressed even if count is at zero
      capture   = 1'b1;
      ld        = 1'b1;
      nxt_state = RUN;
    end else begin
      case (state)
        RUN: begin
          if (bus.en) begin
            if (zero) begin
              tc_nxt = 1'b1;
              if (mode_reg == MODE_PERIODIC) begin
                ld        = 1'b1;
                ld_reload = 1'b1;
              end else begin
                nxt_state = DONE;
              end
            end else begin
              dec = 1'b1;
            end
          end
        end
        IDLE, DONE: ;
        default: nxt_state = IDLE;
      endcase
    end
  end

  assign ld_val = ld_reload ? reload_reg : bus.load_val;

  down_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .load     (ld),
    .dec      (dec),
    .load_val (ld_val),
    .count    (bus.count),
    .zero     (zero)
  );

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.tc   = tc_r;

endmodule

// File: tb/tb_down_counter_reload.sv
// Directed plus random stimulus against a flag/integer model of the timer.
module tb_down_counter_reload;
  localparam int W = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;

  down_counter_reload_if #(.WIDTH(W)) dif ();

  down_counter_reload #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // model: integer count and plain flags for running/finished
  int m_cnt, m_rel;
  bit m_run, m_fin, m_per, m_tc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_rel = 0; m_run = 0; m_fin = 0; m_per = 0; m_tc = 0;
  endtask

  task automatic model_edge(input bit s, input bit p, input bit e, input bit m, input int lv);
    m_tc = 0;
    if (p) begin
      m_cnt = 0; m_run = 0; m_fin = 0;
    end else if (s) begin
      m_cnt = lv; m_rel = lv; m_per = m; m_run = 1; m_fin = 0;
    end else if (m_run && e) begin
      if (m_cnt == 0) begin
        m_tc = 1;
        if (m_per) m_cnt = m_rel;
        else begin m_run = 0; m_fin = 1; end
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_count"}, 32'(dif.count), 32'(m_cnt));
    chk({tag, "_busy"},  32'(dif.busy),  32'(m_run));
    chk({tag, "_done"},  32'(dif.done),  32'(m_fin));
    chk({tag, "_tc"},    32'(dif.tc),    32'(m_tc));
  endtask

  task automatic step(input bit s, input bit p, input bit e, input bit m, input int lv,
                      input string tag);
    dif.start    = s;
    dif.stop     = p;
    dif.en       = e;
    dif.mode     = m;
    dif.load_val = W'(lv);
    @(posedge clk);
    #1;
    model_edge(s, p, e, m, lv % (1 << W));
    check_all(tag);
    dif.start = 1'b0;
    dif.stop  = 1'b0;
  endtask

  initial begin
    int tc_at, npulse;
    bit done_seen;
    dif.start = 0; dif.stop = 0; dif.en = 0; dif.mode = 0; dif.load_val = '0;
    model_reset();

    // 1: reset values, then asynchronous reset mid-count
    #12;
    check_all("rst");
    @(negedge clk) reset = 1'b1;
    step(1, 0, 1, 0, 6, "t1_start");
    step(0, 0, 1, 0, 0, "t1_run");
    step(0, 0, 1, 0, 0, "t1_run");
    chk("t1_mid_count", 32'(dif.count), 32'd4);
    #2 reset = 1'b0;
    #1;
    chk("t1_async_count", 32'(dif.count), 32'd0);
    chk("t1_async_busy",  32'(dif.busy),  32'd0);
    chk("t1_async_done",  32'(dif.done),  32'd0);
    chk("t1_async_tc",    32'(dif.tc),    32'd0);
    model_reset();
    @(negedge clk) reset = 1'b1;
    step(0, 0, 1, 0, 0, "t1_idle");

    // 2: one-shot N=5
    step(1, 0, 1, 0, 5, "t2_start");
    tc_at = -1; npulse = 0;
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 1, 0, 0, "t2");
      if (dif.tc === 1'b1) begin npulse++; if (tc_at < 0) tc_at = i; end
    end
    chk("t2_tc_edge", 32'(tc_at), 32'd6);
    chk("t2_tc_pulses", 32'(npulse), 32'd1);
    chk("t2_done", 32'(dif.done), 32'd1);

    // 3: periodic N=2 for 12 cycles
    step(1, 0, 1, 1, 2, "t3_start");
    npulse = 0; done_seen = 0;
    for (int i = 1; i <= 12; i++) begin
      step(0, 0, 1, 0, 0, "t3");
      if (dif.tc === 1'b1) npulse++;
      if (dif.done === 1'b1) done_seen = 1;
    end
    chk("t3_tc_pulses", 32'(npulse), 32'd4);
    chk("t3_done_seen", 32'(done_seen), 32'd0);

    // 4: one-shot N=3 with en toggling
    step(1, 0, 1, 0, 3, "t4_start");
    tc_at = -1;
    for (int i = 1; i <= 10; i++) begin
      step(0, 0, (i % 2 == 0), 0, 0, "t4");
      if (dif.tc === 1'b1 && tc_at < 0) tc_at = i;
    end
    chk("t4_tc_edge", 32'(tc_at), 32'd8);

    // 5: stop beats start at count 0; restart at count 1
    step(1, 0, 1, 1, 7, "t5_start");
    for (int i = 1; i <= 7; i++) step(0, 0, 1, 0, 0, "t5_run");
    chk("t5_at_zero", 32'(dif.count), 32'd0);
    step(1, 1, 1, 1, 7, "t5_startstop");
    chk("t5_ss_tc", 32'(dif.tc), 32'd0);
    chk("t5_ss_busy", 32'(dif.busy), 32'd0);
    step(1, 0, 1, 1, 7, "t5_start2");
    for (int i = 1; i <= 6; i++) step(0, 0, 1, 0, 0, "t5_run2");
    chk("t5_at_one", 32'(dif.count), 32'd1);
    step(1, 0, 1, 1, 4, "t5_restart");
    chk("t5_restart_count", 32'(dif.count), 32'd4);
    chk("t5_restart_tc", 32'(dif.tc), 32'd0);

    // 6: N=0 one-shot then periodic; also all-ones period
    step(1, 0, 1, 0, 0, "t6_start");
    step(0, 0, 1, 0, 0, "t6_one");
    chk("t6_one_tc", 32'(dif.tc), 32'd1);
    step(0, 0, 1, 0, 0, "t6_done");
    chk("t6_done", 32'(dif.done), 32'd1);
    step(1, 0, 1, 1, 0, "t6_pstart");
    npulse = 0;
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 1, 0, 0, "t6_per");
      if (dif.tc === 1'b1) npulse++;
    end
    chk("t6_per_pulses", 32'(npulse), 32'd5);
    step(1, 0, 1, 1, (1 << W) - 1, "t6_max");
    npulse = 0;
    for (int i = 1; i <= 2 * (1 << W); i++) begin
      step(0, 0, 1, 0, 0, "t6_maxrun");
      if (dif.tc === 1'b1) npulse++;
    end
    chk("t6_max_pulses", 32'(npulse), 32'd2);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 10) == 0, ($urandom % 20) == 0, ($urandom % 4) != 0,
           1'($urandom), int'($urandom % (1 << W)), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/down_counter_reload.md
Name: down_counter_reload

Overview:
Synchronous, parameterised down counter with parallel load, count enable and a terminal-count pulse. It is the down-counting counterpart to the team's up-counter blocks and serves as a programmable interval timer or event divider. It supports one-shot and periodic (auto-reload) operation under a small control FSM. All flops are clocked on the rising edge of one clock; there is no ripple clocking.

Parameters:
WIDTH, 3, counter and load-value width in bits (legal range 2..32)

Ports:
clk  input  1  single clock, rising-edge active
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request: capture load_val and mode, begin counting
stop  input  1  one-cycle abort: return to IDLE
en  input  1  count enable; when low, the count holds
mode  input  1  0 = one-shot, 1 = periodic (auto-reload); sampled only on an accepted start
load_val  input  WIDTH  start value N; the period is N+1 enabled cycles
count  output  WIDTH  current count value
busy  output  1  high in RUN
done  output  1  high in DONE (one-shot finished)
tc  output  1  registered one-cycle terminal-count pulse

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low. While reset is low: count=0, state=IDLE, busy=0, done=0, tc=0, and the internal reload_reg=0 and mode_reg=0. Release is synchronous to clk.
- FSM states are IDLE, RUN and DONE. busy and done are decoded from the state registers, so they change in the cycle after the transition edge.
- Priority on each edge: stop > start > count activity.
- IDLE:
  - start=1: count<=load_val, reload_reg<=load_val, mode_reg<=mode, go to RUN.
  - Otherwise hold, with tc=0.
- RUN, en=1, count!=0: count<=count-1, tc<=0.
- RUN, en=1, count==0: tc<=1 for exactly one cycle.
  - mode_reg=1: count<=reload_reg, remain in RUN.
  - mode_reg=0: count stays 0, go to DONE.
- RUN, en=0: count holds, tc<=0. The FSM stays in RUN.
- RUN, start=1: restart. Recapture load_val and mode, count<=load_val, suppress tc for that cycle even if count==0.
- stop=1 in any state: count<=0, tc<=0, go to IDLE. This applies even when it coincides with start or with a terminal count.
- DONE: count=0 and done=1.
  - start: same action as start in IDLE, go to RUN.
  - stop: go to IDLE.
  - en is ignored.
- Latency: after start accepted at edge 0, with en held high, tc is high during the cycle following edge N+1. In periodic mode tc repeats every N+1 cycles.
- load_val=0: periodic mode gives tc high every enabled cycle (period 1). One-shot gives a single tc, then DONE.
- Arithmetic: modulo-2^WIDTH decrement, but count never underflows because the 0 case always reloads or stops.
- A start value of all ones (2^WIDTH-1) is legal and gives period 2^WIDTH.
- Reset asserted mid-count: immediate return to reset values with no tc emitted.

Decomposition:
- Shared package:
  - State enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Mode constants (MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1).
- One natural sub-module: down_counter_core. It is the WIDTH-bit register with synchronous load, decrement-enable, clear, and a zero-detect output.
- The top level holds the FSM, reload_reg, mode_reg and the tc register.

Test Plan:
1. WIDTH=3, reset low mid-count with count=4 -> count, busy, done and tc all go to 0 immediately (asynchronously). After release, the block sits in IDLE.
2. One-shot, load_val=5, en=1 -> count sequence 5,4,3,2,1,0. tc is high for exactly 1 cycle, 6 cycles after start. Then done=1, busy=0, and count holds 0.
3. Periodic, load_val=2, en=1 for 12 cycles -> count sequence 2,1,0,2,1,0,…. tc pulses every 3 cycles (4 pulses), and done never rises.
4. One-shot, load_val=3, en toggling 1,0,1,0… -> the count decrements only on en=1 cycles. tc arrives at cycle 8, with count held during each en=0 cycle.
5. Periodic, load_val=7, start and stop asserted together at count=0 -> stop wins: no tc, count=0, state IDLE. A separate start at count=1 with load_val=4 -> count=4 with no tc.
6. One-shot, load_val=0 -> tc is high in the cycle after the next edge, then DONE. Periodic with load_val=0 -> tc is high every cycle while en=1.
